// File: rtl/dplca_txop_table.sv
// dplca_txop_table: D-PLCA TO claim table with two-window aging; DPLCA_CLAIM_STATS_EN adds a registered claim popcount
module dplca_txop_table (
    input  logic         clk,
    input  logic         plca_reset,
    input  logic         dplca_en,
    input  logic         dplca_aging,
    input  logic [1:0]   rx_cmd,
    input  logic         claim_valid,
    input  logic [7:0]   claim_id,
    input  logic [7:0]   claim_node_count,
    input  logic [15:0]  aging_cycles,
    output logic [255:0] txop_claim_table,
    output logic         dplca_txop_table_upd,
    output logic         dplca_new_age,
    output logic [7:0]   dplca_txop_id,
    output logic [7:0]   dplca_txop_node_count,
    output logic [8:0]   dplca_claim_count
);
    localparam logic [1:0] BEACON = 2'b00;
    localparam logic [1:0] NONE   = 2'b10;
    logic [255:0] cur_age, prev_age, cur_next;
    logic [15:0]  beacon_cnt, win;
    logic [1:0]   rx_cmd_d;
    logic         rst, beacon, accept, roll;
    assign rst = plca_reset | ~dplca_en;
    assign beacon = (rx_cmd == BEACON) && (rx_cmd_d != BEACON);
    assign accept = claim_valid && (claim_id != 8'hff);
    assign win = (aging_cycles == 16'd0) ? 16'd1 : aging_cycles;
    assign roll = beacon && dplca_aging && (({1'b0, beacon_cnt} + 17'd1) >= {1'b0, win});
    assign cur_next = cur_age | (accept ? (256'd1 << claim_id) : 256'd0);
    assign txop_claim_table = cur_age | prev_age;
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_age <= '0;
            prev_age <= '0;
            beacon_cnt <= '0;
            rx_cmd_d <= NONE;
            dplca_txop_table_upd <= 1'b0;
            dplca_new_age <= 1'b0;
            dplca_txop_id <= '0;
            dplca_txop_node_count <= '0;
        end else begin
            rx_cmd_d <= rx_cmd;
            dplca_txop_table_upd <= beacon;
            dplca_new_age <= roll;
            if (accept) begin
                dplca_txop_id <= claim_id;
                dplca_txop_node_count <= claim_node_count;
            end
            if (roll) begin
                prev_age <= cur_next;
                cur_age <= '0;
            end else begin
                cur_age <= cur_next;
            end
            if (!dplca_aging || roll) beacon_cnt <= '0;
            else if (beacon) beacon_cnt <= beacon_cnt + 16'd1;
        end
    end
`ifdef DPLCA_CLAIM_STATS_EN
    logic [255:0] next_table;
    logic [8:0]   pop, claim_count;
    assign next_table = roll ? cur_next : (cur_next | prev_age);
    always_comb begin
        pop = '0;
        for (int i = 0; i < 256; i++) pop = pop + {8'd0, next_table[i]};
    end
    always_ff @(posedge clk) begin
        if (rst) claim_count <= '0;
        else if (beacon) claim_count <= pop;
    end
    assign dplca_claim_count = claim_count;
`else
    assign dplca_claim_count = 9'd0;
`endif
endmodule

// File: doc/dplca_txop_table.md
DPLCA_TXOP_TABLE -- requirements
Module: dplca_txop_table

Interface
REQ-001 clk  input  1  block clock; all state changes on rising edge.
REQ-002 plca_reset  input  1  synchronous, active-high reset.
REQ-003 dplca_en  input  1  D-PLCA enable; low behaves as reset (REQ-024).
REQ-004 dplca_aging  input  1  aging enable, driven by the D-PLCA control state machine.
REQ-005 rx_cmd  input  2  received PLCA command: BEACON=00, COMMIT=01, NONE=10.
REQ-006 claim_valid  input  1  one-cycle strobe: a transmit opportunity was observed in use.
REQ-007 claim_id  input  8  TO ID of the observed claim; valid with claim_valid.
REQ-008 claim_node_count  input  8  coordinator-advertised node count at the claim; valid with claim_valid.
REQ-009 aging_cycles  input  16  beacon cycles per age window.
REQ-010 txop_claim_table  output  256  bit i = TO ID i claimed in current or previous age window.
REQ-011 dplca_txop_table_upd  output  1  one-cycle pulse: table updated at beacon.
REQ-012 dplca_new_age  output  1  one-cycle pulse: age window rolled over.
REQ-013 dplca_txop_id  output  8  claim_id of most recent accepted claim.
REQ-014 dplca_txop_node_count  output  8  claim_node_count of most recent accepted claim.
REQ-015 dplca_claim_count  output  9  number of set bits in txop_claim_table (see Configuration).

Function
REQ-016 Internal state: cur_age[255:0], prev_age[255:0], beacon_cnt[15:0], rx_cmd_d[1:0]; txop_claim_table = cur_age | prev_age, combinational.
REQ-017 Accepted claim: claim_valid=1 and claim_id != 255; sets cur_age[claim_id] next cycle, registers dplca_txop_id/dplca_txop_node_count; claim_id=255 ignored entirely.
REQ-018 Beacon event: rx_cmd==BEACON and rx_cmd_d!=BEACON; one event per beacon regardless of beacon length.
REQ-019 Beacon event in cycle N: dplca_txop_table_upd=1 in cycle N+1 only; table already reflects all claims up to and including cycle N.
REQ-020 With dplca_aging=1, each beacon event increments beacon_cnt; when beacon_cnt+1 >= max(aging_cycles,1): beacon_cnt<=0, prev_age<=cur_age (incl. same-cycle claim), cur_age<=0, dplca_new_age=1 in cycle N+1 coincident with dplca_txop_table_upd.
REQ-021 aging_cycles=0 treated as 1: every beacon event rolls the age window.
REQ-022 With dplca_aging=0: beacon_cnt held at 0, no rollover, dplca_new_age stays 0, claims still accumulate, dplca_txop_table_upd still pulses.
REQ-023 Claim and rollover in same cycle: claim lands in prev_age; cur_age cleared; claimed ID remains visible in txop_claim_table.

Reset
REQ-024 plca_reset=1 or dplca_en=0 at a clock edge: cur_age, prev_age, beacon_cnt cleared; rx_cmd_d<=NONE; all outputs 0 next cycle; pending pulses suppressed; applies mid-window with no partial rollover.
REQ-025 After reset release, first beacon event restarts the age window count from 0.

Configuration
REQ-026 Macro DPLCA_CLAIM_STATS_EN defined: dplca_claim_count = population count of txop_claim_table, registered, updated in the same cycle as dplca_txop_table_upd and held otherwise; reset value 0.
REQ-027 Macro not defined: dplca_claim_count tied to 0, no popcount logic; all other behaviour identical.

Verification
REQ-028 Reset, then claims IDs 0,3,7 with node_count 8, then beacon -> upd pulse one cycle; table bits 0,3,7 set; txop_id=7, node_count=8.
REQ-029 aging_cycles=3, dplca_aging=1, claim ID 5 once then 6 beacons with no claims -> new_age pulses after beacons 3 and 6; bit 5 set through beacon 5, cleared after beacon 6.
REQ-030 aging_cycles=1, claim ID 9 on same cycle as beacon event -> new_age=1, bit 9 set in table after rollover.
REQ-031 claim_id=255 with claim_valid -> table unchanged, txop_id unchanged; beacon held BEACON for 4 cycles -> single upd pulse.
REQ-032 dplca_aging=0, 10 beacons, aging_cycles=2 -> zero new_age pulses, 10 upd pulses; then dplca_en=0 for one cycle -> table all zero, outputs 0.
REQ-033 DPLCA_CLAIM_STATS_EN defined, claims IDs 0,1,2,254 then beacon -> dplca_claim_count=4 with upd pulse; undefined -> 0.
